// File: rtl/reg_file_arbiter.sv
// Two-requester round-robin front end for a single-port reg_file.
// Serialises read/write requests and returns a response pulse per transaction.
module reg_file_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int REGISTER_DEPTH = 16,
   parameter int ADDRESS_WIDTH  = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [1:0]                   i_req_valid,
   input  logic [1:0]                   i_req_write,
   input  logic [2*ADDRESS_WIDTH-1:0]   i_req_address,
   input  logic [2*DATA_WIDTH-1:0]      i_req_wdata,
   output logic [1:0]                   o_req_ready,
   output logic [1:0]                   o_rsp_valid,
   output logic [DATA_WIDTH-1:0]        o_rsp_data,
   output logic                         o_rsp_error,
   output logic                         o_rf_write_enable,
   output logic                         o_rf_read_enable,
   output logic [ADDRESS_WIDTH-1:0]     o_rf_address,
   output logic [DATA_WIDTH-1:0]        o_rf_write_data,
   input  logic [DATA_WIDTH-1:0]        i_rf_read_data,
   output logic [1:0]                   o_state
);

   // Handshake: a request transfers on a rising edge where i_req_valid[n] and
   // o_req_ready[n] are both 1; ready is only ever offered in IDLE, one-hot.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT = (ADDRESS_WIDTH+1)'(REGISTER_DEPTH);

   state_t                     state;
   logic                       rr_ptr;
   logic                       lat_id;
   logic                       lat_write;
   logic [1:0]                 grant;
   logic                       grant_id;
   logic                       sel_write;
   logic [ADDRESS_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]      sel_wdata;
   logic                       range_err;

   // rr_ptr holds the last served requester; on contention the other one wins.
   always_comb begin
      grant    = 2'b00;
      grant_id = 1'b0;
      if (state == IDLE) begin
         case (i_req_valid)
            2'b01:   begin grant = 2'b01; grant_id = 1'b0; end
            2'b10:   begin grant = 2'b10; grant_id = 1'b1; end
            2'b11:   begin
               grant_id = ~rr_ptr;
               grant    = rr_ptr ? 2'b01 : 2'b10;
            end
            default: begin grant = 2'b00; grant_id = 1'b0; end
         endcase
      end
      sel_write = grant_id ? i_req_write[1] : i_req_write[0];
      sel_addr  = grant_id ? i_req_address[ADDRESS_WIDTH +: ADDRESS_WIDTH]
                           : i_req_address[0 +: ADDRESS_WIDTH];
      sel_wdata = grant_id ? i_req_wdata[DATA_WIDTH +: DATA_WIDTH]
                           : i_req_wdata[0 +: DATA_WIDTH];
      range_err = {1'b0, sel_addr} >= DEPTH_LIMIT;
   end

   assign o_req_ready = grant;
   assign o_state     = state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state             <= IDLE;
         rr_ptr            <= 1'b1;
         lat_id            <= 1'b0;
         lat_write         <= 1'b0;
         o_rsp_valid       <= 2'b00;
         o_rsp_data        <= '0;
         o_rsp_error       <= 1'b0;
         o_rf_write_enable <= 1'b0;
         o_rf_read_enable  <= 1'b0;
         o_rf_address      <= '0;
         o_rf_write_data   <= '0;
      end else begin
         o_rf_write_enable <= 1'b0;
         o_rf_read_enable  <= 1'b0;
         o_rsp_valid       <= 2'b00;
         case (state)
            IDLE: begin
               if (|grant) begin
                  lat_id    <= grant_id;
                  lat_write <= sel_write;
                  rr_ptr    <= grant_id;
                  if (range_err) begin
                     // Out-of-range: skip the reg_file entirely.
                     o_rsp_valid <= grant;
                     o_rsp_error <= 1'b1;
                     o_rsp_data  <= '0;
                     state       <= RESP;
                  end else begin
                     o_rf_address      <= sel_addr;
                     o_rf_write_data   <= sel_wdata;
                     o_rf_write_enable <= sel_write;
                     o_rf_read_enable  <= ~sel_write;
                     state             <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (lat_write) begin
                  o_rsp_valid <= lat_id ? 2'b10 : 2'b01;
                  o_rsp_error <= 1'b0;
                  o_rsp_data  <= '0;
                  state       <= RESP;
               end else begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               o_rsp_valid <= lat_id ? 2'b10 : 2'b01;
               o_rsp_error <= 1'b0;
               o_rsp_data  <= i_rf_read_data;
               state       <= RESP;
            end
            RESP: begin
               o_rsp_error <= 1'b0;
               o_rsp_data  <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
